// File: rtl/soc_system_status_in_if.sv
// ---------------------------------------------------------------------------
// soc_system_status_in_if
// Avalon-MM slave bus bundle for the status input PIO.
//   address    [1:0]  word address of the register
//   chipselect        slave select
//   write_n           active-low write strobe, qualified by chipselect
//   writedata  [31:0] write data
//   readdata   [31:0] registered read data, read latency 1
// master: the bridge / bench side.  slave: the PIO side.
// ---------------------------------------------------------------------------
interface soc_system_status_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/soc_system_status_in.sv
// ---------------------------------------------------------------------------
// soc_system_status_in
// Avalon-MM slave input PIO for the lightweight HPS-to-FPGA bridge.
// Synchronizes an external status bus, latches selected edges into a
// write-1-to-clear capture register and raises a masked level interrupt.
//
// Ports:
//   clk      system clock (single domain)
//   reset_n  asynchronous active-low reset
//   bus      Avalon-MM slave (address, chipselect, write_n, writedata,
//            readdata)
//   in_port  [WIDTH-1:0] asynchronous external status inputs
//   irq      level interrupt: |(edgecapture & irqmask)
//
// Register map (32-bit words, unused high bits read 0):
//   0 DATA        synchronized in_port, read-only
//   1 reserved    reads 0
//   2 IRQMASK     read/write
//   3 EDGECAPTURE read, write-1-to-clear
//
// Parameters:
//   WIDTH        1..32  status bus width
//   EDGE_TYPE    0 rising, 1 falling, 2 any edge
//   SYNC_STAGES  2..4   synchronizer depth
// ---------------------------------------------------------------------------
module soc_system_status_in #(
  parameter int WIDTH       = 32,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  soc_system_status_in_if.slave  bus,
  input  logic [WIDTH-1:0]       in_port,
  output logic                   irq
);

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_RSVD    = 2'd1,
    REG_IRQMASK = 2'd2,
    REG_EDGECAP = 2'd3
  } reg_addr_e;

  // The arm counter runs until the synchronizer and prev register have both
  // been filled with real samples, so the level present at reset release is
  // never mistaken for an edge against the all-zero reset state.
  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_MAX + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] irqmask_q;
  logic [WIDTH-1:0] edgecap_q;
  logic [ARM_W-1:0] arm_cnt_q;
  logic             armed;
  logic             wr_en;
  reg_addr_e        addr_sel;
  logic [31:0]      rd_mux;

  assign addr_sel = reg_addr_e'(bus.address);
  assign wr_en    = bus.chipselect & ~bus.write_n;
  assign sync_s   = sync_q[SYNC_STAGES-1];
  assign armed    = (arm_cnt_q == ARM_W'(ARM_MAX));

  // Synchronizer chain and previous-sample register.
  // NOTE: the sync chain is a handful of flops, not a RAM, so it is reset like
  // any other register; a reset loop over a real memory array would stop it
  // mapping onto block RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      prev_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage read the value its
      // predecessor held before the edge, which is what forms a shift chain.
      sync_q[0] <= in_port;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev_q <= sync_s;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt_q <= '0;
    end else if (!armed) begin
      arm_cnt_q <= arm_cnt_q + ARM_W'(1);
    end
  end

  // Edge detect, held off until the pipeline carries real samples.
  always_comb begin
    // NOTE: defaulting every output first keeps this block purely
    // combinational; a path that skipped an assignment would infer a latch.
    det = '0;
    case (EDGE_TYPE)
      1:       det = ~sync_s & prev_q;
      2:       det = sync_s ^ prev_q;
      default: det = sync_s & ~prev_q;
    endcase
    if (!armed) det = '0;
  end

  assign clr = (wr_en && addr_sel == REG_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;

  // A detect on the same edge as a clear wins, so no edge is ever lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q <= '0;
      edgecap_q <= '0;
    end else begin
      if (wr_en && addr_sel == REG_IRQMASK) irqmask_q <= bus.writedata[WIDTH-1:0];
      edgecap_q <= (edgecap_q & ~clr) | det;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr_sel)
      REG_DATA:    rd_mux = 32'(sync_s);
      REG_RSVD:    rd_mux = '0;
      REG_IRQMASK: rd_mux = 32'(irqmask_q);
      REG_EDGECAP: rd_mux = 32'(edgecap_q);
    endcase
  end

  // Read data is registered unconditionally; reads have no side effects.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else begin
      bus.readdata <= rd_mux;
    end
  end

  assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_soc_system_status_in.sv
// ---------------------------------------------------------------------------
// tb_soc_system_status_in
// Two instances share clock, reset, in_port and bus stimulus: dut0 captures
// rising edges, dut2 captures any edge. The reference model keeps the full
// history of in_port as seen at each clock edge since reset release; with a
// two-stage synchronizer the value visible as "s" before edge e is the
// sample taken at edge e-2, and the previous one is from edge e-3.
// ---------------------------------------------------------------------------
module tb_soc_system_status_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] in_port;
  logic        irq0, irq2;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;

  always #5 clk = ~clk;

  soc_system_status_in_if bus0 ();
  soc_system_status_in_if bus2 ();

  assign bus0.address    = address;
  assign bus0.chipselect = chipselect;
  assign bus0.write_n    = write_n;
  assign bus0.writedata  = writedata;
  assign bus2.address    = address;
  assign bus2.chipselect = chipselect;
  assign bus2.write_n    = write_n;
  assign bus2.writedata  = writedata;

  soc_system_status_in #(.WIDTH(32), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave), .in_port(in_port), .irq(irq0)
  );

  soc_system_status_in #(.WIDTH(32), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2.slave), .in_port(in_port), .irq(irq2)
  );

  // Reference model state
  logic [31:0] hist [$];
  int          edge_n;
  logic [31:0] m_mask;
  logic [31:0] m_cap [2];
  logic [31:0] m_rd  [2];

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] h(int k);
    if (k < 0) return 32'h0;
    return hist[k];
  endfunction

  function automatic logic m_irq(int k);
    return |(m_cap[k] & m_mask);
  endfunction

  function automatic logic [31:0] rd_act(int k);
    return (k == 0) ? bus0.readdata : bus2.readdata;
  endfunction

  function automatic logic irq_act(int k);
    return (k == 0) ? irq0 : irq2;
  endfunction

  task automatic model_reset();
    hist.delete();
    edge_n = 0;
    m_mask = '0;
    for (int k = 0; k < 2; k++) begin
      m_cap[k] = '0;
      m_rd[k]  = '0;
    end
  endtask

  // Advance one clock edge, updating the model from the rules of the block.
  task automatic step();
    logic [31:0] s, p, det, clr, mask_n;
    logic [31:0] cap_n [2];
    logic [31:0] rd_n  [2];
    logic        wr;
    s   = h(edge_n - 2);
    p   = h(edge_n - 3);
    wr  = chipselect && !write_n;
    clr = (wr && address == 2'd3) ? writedata : 32'h0;
    mask_n = (wr && address == 2'd2) ? writedata : m_mask;
    for (int k = 0; k < 2; k++) begin
      det = (k == 0) ? (s & ~p) : (s ^ p);
      if (edge_n < 3) det = '0;
      case (address)
        2'd0:    rd_n[k] = s;
        2'd2:    rd_n[k] = m_mask;
        2'd3:    rd_n[k] = m_cap[k];
        default: rd_n[k] = 32'h0;
      endcase
      cap_n[k] = (m_cap[k] & ~clr) | det;
    end
    hist.push_back(in_port);
    @(posedge clk);
    #1;
    m_mask = mask_n;
    for (int k = 0; k < 2; k++) begin
      m_cap[k] = cap_n[k];
      m_rd[k]  = rd_n[k];
    end
    edge_n++;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus_idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'h0;
  endtask

  task automatic bus_write(logic [1:0] a, logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    step();
    bus_idle();
  endtask

  // After this returns readdata holds the value for address a.
  task automatic bus_read(logic [1:0] a);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    writedata  = 32'h0;
    step();
    bus_idle();
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    reset_n = 1'b0;
    in_port = 32'hA5A5A5A5;
    bus_idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus0.readdata !== 32'h0 || irq0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: readdata=%h irq=%b expected 0/0", bus0.readdata, irq0);
    end
    release_reset();
    steps(6);
    bus_read(2'd0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rd_act(k) !== 32'hA5A5A5A5 || rd_act(k) !== m_rd[k]) begin
        errors++;
        $display("FAIL reset_data[%0d]: got %h expected %h", k, rd_act(k), 32'hA5A5A5A5);
      end
    end
    bus_read(2'd3);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rd_act(k) !== 32'h0 || irq_act(k) !== 1'b0) begin
        errors++;
        $display("FAIL arm_suppress[%0d]: cap=%h irq=%b expected 0/0", k, rd_act(k), irq_act(k));
      end
    end
  endtask

  task automatic test_rising_latency();
    logic exp_irq [3];
    exp_irq = '{1'b0, 1'b0, 1'b1};
    in_port = 32'h0;
    steps(5);
    bus_write(2'd3, 32'hFFFFFFFF);
    bus_write(2'd2, 32'h1);
    in_port = 32'h1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (irq0 !== exp_irq[i] || irq0 !== m_irq(0)) begin
        errors++;
        $display("FAIL rise_latency_e%0d: irq=%b expected %b", i, irq0, exp_irq[i]);
      end
    end
    bus_read(2'd3);
    checks++;
    if (bus0.readdata !== 32'h1 || bus0.readdata !== m_rd[0]) begin
      errors++;
      $display("FAIL rise_capture: got %h expected %h", bus0.readdata, 32'h1);
    end
    bus_write(2'd3, 32'h1);
    checks++;
    if (irq0 !== 1'b0 || irq2 !== 1'b0) begin
      errors++;
      $display("FAIL w1c_irq_drop: irq0=%b irq2=%b expected 0/0", irq0, irq2);
    end
  endtask

  task automatic test_falling();
    logic [31:0] exp_cap [2];
    exp_cap = '{32'h0, 32'h10};
    in_port = 32'h10;
    steps(5);
    bus_write(2'd3, 32'hFFFFFFFF);
    in_port = 32'h0;
    steps(4);
    bus_read(2'd3);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rd_act(k) !== exp_cap[k] || rd_act(k) !== m_rd[k]) begin
        errors++;
        $display("FAIL fall_capture[%0d]: got %h expected %h", k, rd_act(k), exp_cap[k]);
      end
    end
  endtask

  task automatic test_set_wins();
    bus_write(2'd3, 32'hFFFFFFFF);
    bus_write(2'd2, 32'h1);
    in_port = 32'h1;
    steps(5);
    in_port = 32'h0;
    steps(5);
    in_port = 32'h1;
    steps(2);
    // The clear lands on the same edge that detects the new rising edge.
    bus_write(2'd3, 32'h1);
    checks++;
    if (irq0 !== 1'b1 || irq0 !== m_irq(0)) begin
      errors++;
      $display("FAIL set_wins_irq: irq=%b expected 1", irq0);
    end
    bus_read(2'd3);
    checks++;
    if (bus0.readdata !== 32'h1 || irq0 !== 1'b1) begin
      errors++;
      $display("FAIL set_wins_cap: cap=%h irq=%b expected 00000001/1", bus0.readdata, irq0);
    end
  endtask

  task automatic test_mask_and_clear();
    in_port = 32'h0;
    steps(4);
    bus_write(2'd3, 32'hFFFFFFFF);
    in_port = 32'h3;
    steps(4);
    bus_write(2'd2, 32'h2);
    checks++;
    if (irq0 !== 1'b1 || irq0 !== m_irq(0)) begin
      errors++;
      $display("FAIL mask_bit1_irq: irq=%b expected 1", irq0);
    end
    bus_write(2'd3, 32'h2);
    checks++;
    if (irq0 !== 1'b0) begin
      errors++;
      $display("FAIL clear_bit1_irq: irq=%b expected 0", irq0);
    end
    bus_read(2'd3);
    checks++;
    if (bus0.readdata !== 32'h1 || bus0.readdata !== m_rd[0]) begin
      errors++;
      $display("FAIL clear_bit1_cap: got %h expected %h", bus0.readdata, 32'h1);
    end
    bus_write(2'd2, 32'h3);
    checks++;
    if (irq0 !== 1'b1) begin
      errors++;
      $display("FAIL mask3_irq: irq=%b expected 1", irq0);
    end
    bus_write(2'd0, 32'hFFFFFFFF);
    bus_read(2'd0);
    checks++;
    if (bus0.readdata !== 32'h3 || bus0.readdata !== m_rd[0]) begin
      errors++;
      $display("FAIL data_write_ignored: got %h expected %h", bus0.readdata, 32'h3);
    end
    bus_write(2'd1, 32'hFFFFFFFF);
    bus_read(2'd1);
    checks++;
    if (bus0.readdata !== 32'h0) begin
      errors++;
      $display("FAIL reserved_reads_0: got %h expected 0", bus0.readdata);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) in_port = in_port ^ $urandom();
      case ($urandom_range(7))
        0, 1: begin
          chipselect = 1'b1;
          write_n    = 1'b0;
          address    = 2'($urandom_range(3));
          writedata  = $urandom();
        end
        2: begin
          chipselect = 1'b0;
          write_n    = 1'b0;
          address    = 2'($urandom_range(3));
          writedata  = $urandom();
        end
        default: begin
          chipselect = 1'($urandom_range(1));
          write_n    = 1'b1;
          address    = 2'($urandom_range(3));
          writedata  = $urandom();
        end
      endcase
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (rd_act(k) !== m_rd[k] || irq_act(k) !== m_irq(k)) begin
          errors++;
          $display("FAIL random[%0d] cyc %0d: rd=%h irq=%b expected %h/%b",
                   k, i, rd_act(k), irq_act(k), m_rd[k], m_irq(k));
        end
      end
    end
    bus_idle();
  endtask

  task automatic test_reset_mid();
    in_port = 32'h0;
    steps(4);
    bus_write(2'd3, 32'hFFFFFFFF);
    bus_write(2'd2, 32'hF);
    in_port = 32'hF;
    steps(4);
    bus_read(2'd3);
    checks++;
    if (bus0.readdata !== 32'hF || irq0 !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_cap: cap=%h irq=%b expected 0000000f/1", bus0.readdata, irq0);
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rd_act(k) !== 32'h0 || irq_act(k) !== 1'b0) begin
        errors++;
        $display("FAIL async_reset[%0d]: rd=%h irq=%b expected 0/0", k, rd_act(k), irq_act(k));
      end
    end
    in_port = 32'h0000FFFF;
    repeat (2) @(posedge clk);
    release_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (irq_act(k) !== 1'b0 || m_cap[k] !== 32'h0) begin
          errors++;
          $display("FAIL post_reset_irq[%0d] cyc %0d: irq=%b expected 0", k, i, irq_act(k));
        end
      end
    end
    bus_read(2'd3);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rd_act(k) !== 32'h0) begin
        errors++;
        $display("FAIL post_reset_cap[%0d]: got %h expected 0", k, rd_act(k));
      end
    end
    bus_read(2'd2);
    checks++;
    if (bus0.readdata !== 32'h0) begin
      errors++;
      $display("FAIL post_reset_mask: got %h expected 0", bus0.readdata);
    end
    bus_read(2'd0);
    checks++;
    if (bus0.readdata !== 32'h0000FFFF) begin
      errors++;
      $display("FAIL post_reset_data: got %h expected 0000ffff", bus0.readdata);
    end
  endtask

  initial begin
    test_reset();
    test_rising_latency();
    test_falling();
    test_set_wins();
    test_mask_and_clear();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/soc_system_status_in.md
Name: soc_system_status_in

Overview:
- Avalon-MM slave input PIO: the read-side counterpart to the team's output PIO registers.
- Samples a WIDTH-bit external status bus into the clk domain through a synchronizer.
- Latches selected edges into a per-bit capture register with write-1-to-clear semantics.
- Raises a level interrupt to the HPS via a per-bit mask; sits on the lightweight HPS-to-FPGA bridge next to the output PIOs.

Parameters:
- WIDTH, 32, width of in_port and of every register (1..32); unused readdata bits read 0.
- EDGE_TYPE, 0, capture polarity: 0 rising, 1 falling, 2 any edge.
- SYNC_STAGES, 2, synchronizer flop count on in_port (2..4).

Ports:
- clk  input  1  system clock; single clock domain.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  2  word address of the register.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe, qualified by chipselect.
- writedata  input  32  write data.
- in_port  input  WIDTH  asynchronous external status inputs.
- readdata  output  32  registered read data, read latency 1.
- irq  output  1  level interrupt: OR of (edgecapture AND irqmask).

Behaviour:
- Reset is asynchronous and active-low; clk is the only clock.
  - Reset clears: all sync flops, the prev register, irqmask, edgecapture, readdata, the arm counter; irq = 0.
  - Asserting reset mid-operation clears everything immediately, including pending captures.
- Register map (32-bit words):
  - 0 DATA: read-only synchronized in_port; writes ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQMASK: read/write; bit i enables edgecapture[i] onto irq.
  - 3 EDGECAPTURE: read; write-1-to-clear per bit; 0 bits in writedata leave the bit unchanged.
- Write accepted on the rising clk edge when chipselect = 1 and write_n = 0. No wait states.
- Read data:
  - readdata is registered every cycle from the mux selected by address (zero-extended).
  - Valid on the cycle after address is presented (readLatency 1).
  - A read has no side effects; reading EDGECAPTURE does not clear it.
- Synchronizer: sync[0] <= in_port; sync[k] <= sync[k-1]; s = sync[SYNC_STAGES-1]. prev <= s every cycle.
- Edge detect (combinational):
  - rising: s & ~prev
  - falling: ~s & prev
  - any: s ^ prev
- Arm counter:
  - Counts 0..SYNC_STAGES+1 after reset release, then saturates.
  - Edge detect is gated off until saturated, so a static input level at reset release produces no capture.
- Capture: edgecapture[i] <= (edgecapture[i] & ~clr[i]) | det[i].
  - Simultaneous detect and clear on the same bit: set wins; the edge is not lost.
- Latency with SYNC_STAGES = 2, once armed:
  - in_port toggle settled before edge E0 → s changes after E1 → edgecapture and irq set after E2.
  - DATA read issued after E1 returns the new value on readdata after E2.
- irq is combinational from registers, so it drops the cycle after the clearing write or the mask-clearing write.
- Glitches shorter than one clk period may be missed. That is acceptable; no pulse stretching.

Test Plan:
- Reset, then in_port = 0xA5A5A5A5 held → DATA read = 0xA5A5A5A5. EDGECAPTURE read = 0 (arm suppression). irq = 0.
- EDGE_TYPE = 0, IRQMASK = 0x1, in_port[0] 0→1 → edgecapture = 0x1 and irq = 1 exactly 3 clk edges after the toggle. Write 0x1 to addr 3 → irq = 0 next cycle.
- EDGE_TYPE = 0, in_port[4] 1→0 → no capture. Rebuild with EDGE_TYPE = 2 → same toggle sets edgecapture = 0x10.
- Write 0x1 to addr 3 in the same cycle a new rising edge on bit 0 is detected → edgecapture[0] remains 1, irq stays 1.
- Bits 0, 1 captured, IRQMASK = 0x2:
  - Clear bit 1 via write 0x2 → edgecapture = 0x1, irq = 0.
  - Write IRQMASK = 0x3 → irq = 1.
  - Write addr 0 = 0xFFFFFFFF → DATA unchanged.
- Assert reset_n low mid-capture with edgecapture = 0xF → all registers, readdata and irq = 0 asynchronously. No spurious capture within SYNC_STAGES+1 cycles of reset release.
